spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Synthesizable SPI master that issues 10-bit command frames to the SPI slave / dual-port-RAM wrapper. It replaces the behavioural stimulus master with RTL that a host-side controller drives through a simple valid/ready command port. It serialises {op, data} MSB first on `mosi` under `ss_n` and returns read data captured from `miso`. The serial link is clocked by the system clock: one bit per `clk` cycle, with no separate SCK.

## Interface
- `GAP_CYCLES`, 5: cycles `ss_n` is held high between frames (minimum 1).
- `RD_LAT`, 2: cycles between the last command bit and the first `miso` data bit of a read-data frame (minimum 0).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host offers a command.
- `cmd_ready`  out  1  block accepts a command this cycle.
- `cmd_op`  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- `cmd_data`  in  8  address or data byte (don't-care payload for op 11, still shifted).
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` is valid.
- `rsp_data`  out  8  byte read from the slave; holds its value until the next pulse.
- `busy`  out  1  high from accept through the end of the gap.
- `mosi`  out  1  serial data to the slave.
- `ss_n`  out  1  active-low slave select.
- `miso`  in  1  serial data from the slave.

## Operation
- **States:** IDLE, SHIFT, WAIT_RD, RECV, GAP.
- **IDLE:**
  - `cmd_ready`=1; `ss_n`=1; `mosi`=0.
  - On `cmd_valid`&&`cmd_ready`, latch frame = {`cmd_op`, `cmd_data`}, then go to SHIFT.
- **SHIFT:**
  - `ss_n`=0; `mosi`=frame[9-k] during bit cycle k=0..9.
  - After bit 9: op 11 goes to WAIT_RD if `RD_LAT`>0, otherwise to RECV. All other ops go to GAP.
- **WAIT_RD:**
  - `ss_n`=0; `mosi`=0; lasts `RD_LAT` cycles, then RECV.
- **RECV:**
  - `ss_n`=0; `mosi`=0.
  - Sample `miso` on 8 consecutive edges, MSB first, into the shift register.
  - After the 8th sample, go to GAP; `rsp_valid` pulses in the first GAP cycle.
- **GAP:**
  - `ss_n`=1; `mosi`=0; lasts `GAP_CYCLES` cycles, then IDLE.
- `cmd_ready`=0 in every state except IDLE. Commands offered while busy are neither accepted nor queued; the host holds `cmd_valid`.
- The block does not track slave state; the host is responsible for op order (for example, read address before read data).
- Bit counter: 4 bits, counts 0..9 in SHIFT and 0..7 in RECV. The wait/gap counter is sized by `$clog2` of max(`GAP_CYCLES`, `RD_LAT`)+1.

## Timing
- **Reset values:** state IDLE, `ss_n`=1, `mosi`=0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=8'h00.
- **Reset mid-operation:** the frame is aborted. `ss_n`=1 on the edge after `rst` is sampled, no `rsp_valid` is issued, and the next accept starts a fresh frame.
- **Accept edge T:**
  - `ss_n` falls and `mosi`=bit 9 from T+1.
  - Bit 0 is driven during T+10.
  - `ss_n` rises at T+11 for ops 00/01/10.
- **Read data (op 11):**
  - `miso` is sampled at the end of cycles T+11+`RD_LAT` .. T+18+`RD_LAT`.
  - `rsp_valid` is high in cycle T+19+`RD_LAT`, the same cycle `ss_n` rises.
- **Accept-to-accept spacing:** 10+`GAP_CYCLES`+1 cycles for write/address ops; 18+`RD_LAT`+`GAP_CYCLES`+1 for read-data.
- `busy` = (state != IDLE).

## Structure
- Package `spi_pkg`:
  - op constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_W=10, DATA_W=8;
  - state enum.
  The slave side imports the same op constants.
- One sub-module, `spi_shift_reg`: a 10-bit shift register with load, shift-out (MSB) and shift-in (LSB from `miso`) controls. The FSM and counters live in `spi_master_ctrl`.

## Test plan
- Reset held 3 cycles, then released → `ss_n`=1, `mosi`=0, `cmd_ready`=1, `rsp_valid`=0 throughout reset and after release.
- Op 00, data 8'h01 → `mosi` = 0,0,0,0,0,0,0,0,0,1 over 10 cycles with `ss_n`=0, then `ss_n`=1 for exactly 5 cycles, then `cmd_ready`=1.
- Op 01, data 8'hAA, then op 10, data 8'h01, back-to-back with `cmd_valid` held → frames 0110101010 and 1000000001; the second is accepted only after the gap; `cmd_ready`=0 during the first.
- Op 11 with a slave model returning 8'hA5 with `RD_LAT`=2 → `ss_n` stays low for 20 cycles; `rsp_valid` pulses once with `rsp_data`=8'hA5 in the cycle `ss_n` rises.
- `rst` asserted at bit 4 of an op 11 frame → `ss_n`=1 on the next edge, no `rsp_valid`; a following op 00, data 8'h01 frame is bit-exact.
- Param sweep: `RD_LAT`=0 and `GAP_CYCLES`=1 → read data is sampled starting the cycle after bit 0, and there is a 1-cycle `ss_n` high gap.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared op codes, frame widths and controller states for the SPI master/slave pair.
package spi_pkg;
   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT_RD,
      ST_RECV,
      ST_GAP
   } state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: 10-bit frame register; loads a command, shifts it out MSB first, shifts miso in at the LSB.
module spi_shift_reg
   import spi_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic               i_shift_out,
   input  logic               i_shift_in,
   input  logic               i_miso,
   input  logic [FRAME_W-1:0] i_data,
   output logic               o_msb,
   output logic [DATA_W-1:0]  o_rx_next
);
   logic [FRAME_W-1:0] r_q;
   always_ff @(posedge i_clk) begin
      if (i_rst)            r_q <= '0;
      else if (i_load)      r_q <= i_data;
      else if (i_shift_in)  r_q <= {r_q[FRAME_W-2:0], i_miso};
      else if (i_shift_out) r_q <= {r_q[FRAME_W-2:0], 1'b0};
   end
   assign o_msb = r_q[FRAME_W-1];
   // byte as it will stand once the current miso bit is shifted in
   assign o_rx_next = {r_q[DATA_W-2:0], i_miso};
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: valid/ready command port to 10-bit SPI frames on mosi/ss_n, one bit per clk;
// read-data frames capture 8 miso bits after RD_LAT cycles and return them on rsp_valid/rsp_data.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int GAP_CYCLES = 5,
   parameter int RD_LAT     = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [DATA_W-1:0] i_cmd_data,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_busy,
   output logic              o_mosi,
   output logic              o_ss_n,
   input  logic              i_miso
);
   localparam int MAXC = (GAP_CYCLES > RD_LAT) ? GAP_CYCLES : RD_LAT;
   localparam int CW   = $clog2(MAXC + 1);
   state_t            r_state, w_next;
   logic [3:0]        r_bcnt;
   logic [CW-1:0]     r_wcnt;
   logic              r_is_rd;
   logic              w_accept, w_msb, w_rx_done;
   logic [DATA_W-1:0] w_rx_next;
   assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
   assign w_rx_done = (r_state == ST_RECV) && (r_bcnt == 4'd7);
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    w_next = i_cmd_valid ? ST_SHIFT : ST_IDLE;
         ST_SHIFT:   if (r_bcnt == 4'd9) w_next = !r_is_rd ? ST_GAP : ((RD_LAT > 0) ? ST_WAIT_RD : ST_RECV);
         ST_WAIT_RD: if (r_wcnt == CW'(RD_LAT - 1)) w_next = ST_RECV;
         ST_RECV:    if (r_bcnt == 4'd7) w_next = ST_GAP;
         ST_GAP:     if (r_wcnt == CW'(GAP_CYCLES - 1)) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end
   // counters restart on every state change, so each state counts from zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bcnt      <= '0;
         r_wcnt      <= '0;
         r_is_rd     <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
      end else begin
         r_bcnt      <= (w_next != r_state) ? '0 : r_bcnt + 4'd1;
         r_wcnt      <= (w_next != r_state) ? '0 : r_wcnt + CW'(1);
         o_rsp_valid <= w_rx_done;
         if (w_accept)  r_is_rd    <= (i_cmd_op == OP_RD_DATA);
         if (w_rx_done) o_rsp_data <= w_rx_next;
      end
   end
   spi_shift_reg u_sr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (w_accept),
      .i_shift_out (r_state == ST_SHIFT),
      .i_shift_in  (r_state == ST_RECV),
      .i_miso      (i_miso),
      .i_data      ({i_cmd_op, i_cmd_data}),
      .o_msb       (w_msb),
      .o_rx_next   (w_rx_next)
   );
   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_ss_n      = !((r_state == ST_SHIFT) || (r_state == ST_WAIT_RD) || (r_state == ST_RECV));
   assign o_mosi      = (r_state == ST_SHIFT) && w_msb;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven frame checks on two parameterisations (RD_LAT=2/GAP=5 and RD_LAT=0/GAP=1)
// plus reset and mid-frame reset sequences.
module tb_spi_master_ctrl;
   typedef struct {
      logic       sel;
      logic [1:0] op;
      logic [7:0] data;
      logic [7:0] miso_byte;
      logic [9:0] frame;
      logic [7:0] exp_rsp;
      logic       hold;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, valid = 1'b0, miso = 1'b0, sel = 1'b0;
   logic [1:0] op = 2'b00;
   logic [7:0] data = 8'h00;
   logic rdy0, rv0, busy0, mosi0, ssn0, rdy1, rv1, busy1, mosi1, ssn1;
   logic [7:0] rd0, rd1;
   logic rdy, rv, busy, mosi, ssn;
   logic [7:0] rd;
   int n_chk = 0, n_fail = 0;
   logic [7:0] last_rsp [2];
   vec_t tbl [7];
   always #5 clk = ~clk;
   spi_master_ctrl #(.GAP_CYCLES(5), .RD_LAT(2)) u0 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid && !sel), .o_cmd_ready(rdy0),
      .i_cmd_op(op), .i_cmd_data(data), .o_rsp_valid(rv0), .o_rsp_data(rd0),
      .o_busy(busy0), .o_mosi(mosi0), .o_ss_n(ssn0), .i_miso(miso));
   spi_master_ctrl #(.GAP_CYCLES(1), .RD_LAT(0)) u1 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid && sel), .o_cmd_ready(rdy1),
      .i_cmd_op(op), .i_cmd_data(data), .o_rsp_valid(rv1), .o_rsp_data(rd1),
      .o_busy(busy1), .o_mosi(mosi1), .o_ss_n(ssn1), .i_miso(miso));
   assign rdy  = sel ? rdy1  : rdy0;
   assign rv   = sel ? rv1   : rv0;
   assign busy = sel ? busy1 : busy0;
   assign mosi = sel ? mosi1 : mosi0;
   assign ssn  = sel ? ssn1  : ssn0;
   assign rd   = sel ? rd1   : rd0;
   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (dut%0d, t=%0t): got %0h expected %0h", nm, sel, $time, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run(input vec_t v);
      int lat, gap, w;
      lat   = v.sel ? 0 : 2;
      gap   = v.sel ? 1 : 5;
      sel   = v.sel;
      op    = v.op;
      data  = v.data;
      valid = 1'b1;
      w = 0;
      while (!rdy && w < 100) begin
         step();
         w++;
      end
      chk("accept_timeout", 10'(w < 100), 10'd1);
      step();
      if (!v.hold) valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("frame_ssn", 10'(ssn), 10'd0);
         chk("frame_mosi", 10'(mosi), 10'(v.frame[9-k]));
         chk("frame_busy_ready", 10'({busy, rdy}), 10'b10);
         step();
      end
      if (v.op == 2'b11) begin
         for (int i = 0; i < lat; i++) begin
            chk("wait_ssn_mosi", 10'({ssn, mosi}), 10'b00);
            step();
         end
         for (int i = 0; i < 8; i++) begin
            miso = v.miso_byte[7-i];
            chk("recv_ssn_mosi_rv", 10'({ssn, mosi, rv}), 10'b000);
            step();
         end
         miso = 1'b0;
         last_rsp[v.sel] = v.exp_rsp;
      end
      for (int g = 0; g < gap; g++) begin
         chk("gap_ssn_mosi_rdy", 10'({ssn, mosi, rdy}), 10'b100);
         chk("gap_rsp_valid", 10'(rv), 10'((v.op == 2'b11) && (g == 0)));
         if (v.op == 2'b11 && g == 0) chk("rsp_data", 10'(rd), 10'(v.exp_rsp));
         step();
      end
      chk("idle_ready_ssn_busy_rv", 10'({rdy, ssn, busy, rv}), 10'b1100);
      chk("rsp_data_hold", 10'(rd), 10'(last_rsp[v.sel]));
   endtask
   initial begin
      tbl[0] = '{1'b0, 2'b00, 8'h01, 8'h00, 10'b0000000001, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 2'b01, 8'hAA, 8'h00, 10'b0110101010, 8'h00, 1'b1};
      tbl[2] = '{1'b0, 2'b10, 8'h01, 8'h00, 10'b1000000001, 8'h00, 1'b0};
      tbl[3] = '{1'b0, 2'b11, 8'h00, 8'hA5, 10'b1100000000, 8'hA5, 1'b0};
      tbl[4] = '{1'b1, 2'b11, 8'hFF, 8'h3C, 10'b1111111111, 8'h3C, 1'b0};
      tbl[5] = '{1'b1, 2'b00, 8'h01, 8'h00, 10'b0000000001, 8'h00, 1'b0};
      tbl[6] = '{1'b0, 2'b11, 8'h5A, 8'h96, 10'b1101011010, 8'h96, 1'b0};
      last_rsp[0] = 8'h00;
      last_rsp[1] = 8'h00;
      #1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_dut0", 10'({ssn0, mosi0, rdy0, rv0}), 10'b1010);
         chk("rst_dut1", 10'({ssn1, mosi1, rdy1, rv1}), 10'b1010);
      end
      rst = 1'b0;
      step();
      chk("post_rst_dut0", 10'({ssn0, mosi0, rdy0, rv0, busy0}), 10'b10100);
      chk("post_rst_dut1", 10'({ssn1, mosi1, rdy1, rv1, busy1}), 10'b10100);
      chk("post_rst_rsp_data", 10'({rd0, 2'b00}), 10'd0);
      for (int i = 0; i < 7; i++) run(tbl[i]);
      sel   = 1'b0;
      op    = 2'b11;
      data  = 8'h00;
      valid = 1'b1;
      chk("midrst_ready", 10'(rdy0), 10'd1);
      step();
      valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("midrst_bit4_ssn", 10'(ssn0), 10'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_abort", 10'({ssn0, mosi0, rv0, rdy0}), 10'b1001);
      chk("midrst_rsp_data", 10'(rd0), 10'd0);
      last_rsp[0] = 8'h00;
      last_rsp[1] = 8'h00;
      miso = 1'b1;
      for (int c = 0; c < 30; c++) begin
         chk("midrst_quiet", 10'({ssn0, rv0}), 10'b10);
         step();
      end
      miso = 1'b0;
      run(tbl[0]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
